uut_perf_meter: RTL
===================

Name: uut_perf_meter

Overview:
- Measures the clk-cycle latency of one UUT run, from the `uut_start` pulse issued by the autotest FSM to the UUT's `uut_finish` response.
- Latches the result and presents it as a byte stream. The autotest FSM pulls the bytes one at a time and writes them to the SD card through `sdspihost` (`w_byte` path).
- Sits alongside the UUT, downstream of the autotest FSM's start output, and upstream of its result-logging path.

Parameters:
- `COUNTER_WIDTH`, 32: cycle counter width in bits. Must be a multiple of 8 and at least 16.
- `TIMEOUT_CYCLES`, 0: abort threshold in cycles. 0 disables the timeout.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: single-cycle run start, tied to `uut_start`.
- `finish` in 1: UUT completion level, tied to `uut_finish`.
- `clear` in 1: synchronous return to IDLE.
- `byte_rd` in 1: consumer pulse that pops the current byte.
- `busy` out 1: high while a run is being measured.
- `done` out 1: high while a result is held.
- `cycles` out `COUNTER_WIDTH`: live or latched count.
- `byte_out` out 8: current result byte.
- `byte_valid` out 1: `byte_out` holds an unread byte.
- `byte_last` out 1: the current byte is the final byte of the record.

Behaviour:
- Reset values: state=IDLE; `busy`=`done`=`byte_valid`=`byte_last`=0; `cycles`=0; `byte_out`=0; internal flags and byte index = 0.
- States: IDLE, COUNT, DONE.
- IDLE -> COUNT on `start`: `cycles` loads 1, flags clear.
- In COUNT:
  - `finish`=0: `cycles` increments by 1 and saturates at all-ones. Reaching all-ones sets `ovf`.
  - `finish`=1 sampled: `cycles` holds and the state goes to DONE.
  - Latency definition: `start` in cycle 0 and `finish` first high in cycle k gives `cycles`=k.
  - If `TIMEOUT_CYCLES`!=0 and `cycles`==`TIMEOUT_CYCLES` with `finish`=0: set `tmo`, hold `cycles`, go to DONE.
  - `start` in COUNT is ignored.
- DONE entry: byte index=0, `byte_valid`=1, `done`=1, `busy`=0.
- Record format, byte order:
  - count bytes, MSB first (`COUNTER_WIDTH`/8 bytes);
  - then one status byte = {5'b0, `ovf`, `tmo`, 1'b1}.
- Record length N = `COUNTER_WIDTH`/8 + 1.
- `byte_out` is combinational from the latched record and the byte index, so it is valid in the same cycle as `byte_valid`.
- `byte_last`=1 when index==N-1 and `byte_valid`=1.
- Popping:
  - `byte_rd` with `byte_valid`=1: index increments. Popping the last byte drops `byte_valid` to 0; `done` stays 1.
  - `byte_rd` with `byte_valid`=0 is ignored; no wrap-around.
- `start` in DONE restarts the measurement (same as from IDLE) and discards any unread bytes.
- `start` and `byte_rd` in the same cycle: `start` wins.
- `clear` in any state -> IDLE, all outputs at reset values. `clear` has priority over `start`.
- `rst` mid-run aborts immediately; no partial result is kept.
- `busy`=1 exactly while in COUNT.

Optional Feature:
- Macro: `UUT_PERF_METER_MINMAX_EN`.
- When defined:
  - Registers `min` (reset to all-ones) and `max` (reset to 0) track the `cycles` value of every run that ends by `finish` (runs ending by `tmo` are excluded).
  - Both registers are cleared only by `rst` or `clear`, not by `start`.
  - Record becomes: count, min, max (each MSB first), then status. N = 3·`COUNTER_WIDTH`/8 + 1.
- When undefined: no min/max registers, and the record is exactly as described in Behaviour.

Test Plan:
- Basic latency (`COUNTER_WIDTH`=32): `start` at cycle 0, `finish` high at cycle 10 -> `cycles`=10, `done`=1. Popping all bytes yields 00,00,00,0A,01, with `byte_last` on the 5th byte, then `byte_valid`=0.
- Immediate finish: `finish` high in the cycle right after `start` -> `cycles`=1; status byte=01.
- Timeout (`TIMEOUT_CYCLES`=100): `finish` held 0 -> DONE with `cycles`=100 and status byte=03. Separately, `COUNTER_WIDTH`=16 with `finish` held 0 for 70000 cycles -> `cycles`=FFFF, `ovf`=1, status byte=05.
- Boundary events:
  - `start` during COUNT has no effect;
  - `start` during DONE after 2 pops restarts, with index reset to 0 on the next DONE;
  - `clear` and `start` in the same cycle -> IDLE.
- Async `rst` asserted mid-COUNT between clock edges -> all outputs 0 immediately.
- With `UUT_PERF_METER_MINMAX_EN`: runs of 20, 8 and 15 cycles -> third record is count 0000000F, min 00000008, max 00000014, status 01.

Source files
------------

// File: rtl/uut_perf_meter.sv
// Cycle-latency meter for one UUT run; latches the result and serves it as a byte record.
// Optional build macro UUT_PERF_METER_MINMAX_EN adds min/max tracking across runs to the record.
//
// state   | meaning
// S_IDLE  | no run measured, outputs at rest
// S_COUNT | run in progress, counting cycles since start
// S_DONE  | result held, bytes available to the consumer
module uut_perf_meter #(
    parameter int COUNTER_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     finish,
    input  logic                     clear,
    input  logic                     byte_rd,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] cycles,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    output logic                     byte_last
);

    localparam int NB = COUNTER_WIDTH / 8;
`ifdef UUT_PERF_METER_MINMAX_EN
    localparam int N  = 3 * NB + 1;
`else
    localparam int N  = NB + 1;
`endif
    localparam int RW = N * 8;
    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0]            LAST_IDX = IW'(N - 1);
    localparam logic [COUNTER_WIDTH-1:0] ONES     = '1;
    localparam logic [COUNTER_WIDTH-1:0] TMO_VAL  = COUNTER_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cycles_q, cycles_d, cyc_inc;
    logic                     ovf_q, ovf_d, tmo_q, tmo_d;
    logic                     valid_q, valid_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [RW-1:0]            rec;
`ifdef UUT_PERF_METER_MINMAX_EN
    logic [COUNTER_WIDTH-1:0] min_q, min_d, max_q, max_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cycles_q <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
`ifdef UUT_PERF_METER_MINMAX_EN
            min_q    <= ONES;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
`ifdef UUT_PERF_METER_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        cyc_inc  = cycles_q + 1'b1;
`ifdef UUT_PERF_METER_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        if (clear) begin
            state_d  = S_IDLE;
            cycles_d = '0;
            ovf_d    = 1'b0;
            tmo_d    = 1'b0;
            valid_d  = 1'b0;
            idx_d    = '0;
`ifdef UUT_PERF_METER_MINMAX_EN
            min_d    = ONES;
            max_d    = '0;
`endif
        end else if (start && state_q != S_COUNT) begin
            // The start cycle itself counts as cycle 0, so the first COUNT cycle holds 1.
            state_d  = S_COUNT;
            cycles_d = COUNTER_WIDTH'(1);
            ovf_d    = 1'b0;
            tmo_d    = 1'b0;
            valid_d  = 1'b0;
            idx_d    = '0;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (finish) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        idx_d   = '0;
`ifdef UUT_PERF_METER_MINMAX_EN
                        if (cycles_q < min_q) min_d = cycles_q;
                        if (cycles_q > max_q) max_d = cycles_q;
`endif
                    end else if (TIMEOUT_CYCLES != 0 && cycles_q == TMO_VAL) begin
                        state_d = S_DONE;
                        tmo_d   = 1'b1;
                        valid_d = 1'b1;
                        idx_d   = '0;
                    end else if (cycles_q != ONES) begin
                        cycles_d = cyc_inc;
                        if (cyc_inc == ONES) ovf_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (byte_rd && valid_q) begin
                        if (idx_q == LAST_IDX) valid_d = 1'b0;
                        else                   idx_d   = idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UUT_PERF_METER_MINMAX_EN
    assign rec = {cycles_q, min_q, max_q, 5'b0, ovf_q, tmo_q, 1'b1};
`else
    assign rec = {cycles_q, 5'b0, ovf_q, tmo_q, 1'b1};
`endif

    always_comb begin
        byte_out = 8'h00;
        if (valid_q) byte_out = rec[8*(N-1-int'(idx_q)) +: 8];
    end

    assign busy       = (state_q == S_COUNT);
    assign done       = (state_q == S_DONE);
    assign cycles     = cycles_q;
    assign byte_valid = valid_q;
    assign byte_last  = valid_q && (idx_q == LAST_IDX);

endmodule
